dpram_arbiter: RTL

Two-requester arbiter that shares the read/write port A of a single-clock dual-port block RAM, such as a work-RAM or VRAM buffer in the ulx3s SNES memory subsystem. It accepts level-held requests from two masters, for example CPU-side and DMA-side logic. It grants them round-robin and issues one registered RAM command per cycle. Read data returns to the winning requester with a one-cycle valid pulse. Port B of the RAM is not touched by this block.

---
 rtl/dpram_arbiter_if.sv | 24 ++
 rtl/dpram_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/dpram_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: one instance per requester.
// The requester holds req (with we/addr/wdata stable) until it sees the one-cycle ack pulse.
interface dpram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters; one registered
// command per cycle, read data returned with a one-cycle rvalid pulse three cycles after the request.
module dpram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  dpram_arbiter_if.slave        port0,
  dpram_arbiter_if.slave        port1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_enable,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // Handshake: reqN is level-held with we/addr/wdata stable; ackN pulses for exactly
  // the cycle the command sits on the RAM port. rvalidN pulses when rdataN is fresh.
  logic last;
  logic tag1_valid, tag1_id;
  logic tag2_valid, tag2_id;

  logic eligible0, eligible1;
  logic grant0, grant1;

  // A requester whose ack is high is masked so a still-held req is not granted twice.
  always_comb begin
    eligible0 = port0.req & ~port0.ack;
    eligible1 = port1.req & ~port1.ack;
    grant0    = eligible0 & (~eligible1 | last);
    grant1    = eligible1 & (~eligible0 | ~last);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port0.ack    <= 1'b0;
      port1.ack    <= 1'b0;
      port0.rvalid <= 1'b0;
      port1.rvalid <= 1'b0;
      port0.rdata  <= '0;
      port1.rdata  <= '0;
      ram_address  <= '0;
      ram_data     <= '0;
      ram_enable   <= 1'b0;
      ram_wren     <= 1'b0;
      last         <= 1'b1;
      tag1_valid   <= 1'b0;
      tag1_id      <= 1'b0;
      tag2_valid   <= 1'b0;
      tag2_id      <= 1'b0;
    end else begin
      port0.ack  <= grant0;
      port1.ack  <= grant1;
      ram_enable <= grant0 | grant1;
      if (grant0) begin
        ram_address <= port0.addr;
        ram_data    <= port0.wdata;
        ram_wren    <= port0.we;
        last        <= 1'b0;
        tag1_valid  <= ~port0.we;
        tag1_id     <= 1'b0;
      end else if (grant1) begin
        ram_address <= port1.addr;
        ram_data    <= port1.wdata;
        ram_wren    <= port1.we;
        last        <= 1'b1;
        tag1_valid  <= ~port1.we;
        tag1_id     <= 1'b1;
      end else begin
        ram_wren   <= 1'b0;
        tag1_valid <= 1'b0;
        tag1_id    <= 1'b0;
      end

      // Stage 2 lines up with ram_q, which is valid the cycle after the command.
      tag2_valid   <= tag1_valid;
      tag2_id      <= tag1_id;
      port0.rvalid <= tag2_valid & ~tag2_id;
      port1.rvalid <= tag2_valid & tag2_id;
      if (tag2_valid && !tag2_id) port0.rdata <= ram_q;
      if (tag2_valid && tag2_id)  port1.rdata <= ram_q;
    end
  end

endmodule
